sram_port_arbiter: RTL and testbench

- Single-ported SRAM controller between the GPU read path and the scan-chain loader write path.
- Arbitrates per cycle and registers the SRAM command pins (cen, wen, addr, din, sram_sel).
- Tracks outstanding reads so rd_valid aligns with SRAM output data.
- Provides a load-mode handshake that drains reads before granting the loader exclusive access.

---
 rtl/sram_port_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// Single-port SRAM arbiter between the GPU read path and the scan-chain loader write path.
// Optional statistics counters are built when the macro ARB_STATS_EN is defined.
module sram_port_arbiter #(
  parameter int ADDR_W      = 11,
  parameter int WDATA_W     = 8,
  parameter int RDATA_W     = 16,
  parameter int SRAM_LAT    = 1,
  parameter int WR_MAX_WAIT = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rd_req,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic               rd_gnt,
  output logic               rd_valid,
  output logic [RDATA_W-1:0] rd_data,
  input  logic               wr_valid,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic               wr_sel,
  input  logic [WDATA_W-1:0] wr_data,
  output logic               wr_ready,
  input  logic               load_req,
  output logic               load_ack,
  output logic               sram_cen,
  output logic               sram_wen,
  output logic [ADDR_W-1:0]  sram_addr,
  output logic [WDATA_W-1:0] sram_din,
  output logic               sram_sel,
  input  logic [RDATA_W-1:0] sram_dout,
  output logic [15:0]        stat_rd,
  output logic [15:0]        stat_wr,
  output logic [15:0]        stat_stall
);

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_LOAD   = 2'd2
  } state_e;

  localparam logic [3:0] WAIT_MAX = 4'(WR_MAX_WAIT);

  state_e              state_q, state_d;
  logic [3:0]          wait_q, wait_d;
  logic [SRAM_LAT:0]   pipe_q, pipe_d;
  logic                cen_q, cen_d;
  logic                wen_q, wen_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WDATA_W-1:0]  din_q, din_d;
  logic                sel_q, sel_d;

  // Grant selection and mode transitions
  always_comb begin
    rd_gnt   = 1'b0;
    wr_ready = 1'b0;
    state_d  = state_q;
    case (state_q)
      ST_NORMAL: begin
        if (rd_req && wr_valid) begin
          if (wait_q == WAIT_MAX) begin
            wr_ready = 1'b1;
          end else begin
            rd_gnt = 1'b1;
          end
        end else begin
          rd_gnt   = rd_req;
          wr_ready = wr_valid;
        end
        state_d = load_req ? ST_DRAIN : ST_NORMAL;
      end
      ST_DRAIN: begin
        if (!load_req) begin
          state_d = ST_NORMAL;
        end else if (pipe_q == '0) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_LOAD: begin
        wr_ready = wr_valid;
        state_d  = load_req ? ST_LOAD : ST_NORMAL;
      end
      default: begin
        state_d = ST_NORMAL;
      end
    endcase
  end

  // Write starvation counter, SRAM command pins and read-valid pipeline
  always_comb begin
    if (wr_ready || !wr_valid) begin
      wait_d = 4'd0;
    end else if (wait_q != WAIT_MAX) begin
      wait_d = wait_q + 4'd1;
    end else begin
      wait_d = wait_q;
    end

    cen_d  = 1'b1;
    wen_d  = 1'b1;
    addr_d = addr_q;
    din_d  = din_q;
    sel_d  = sel_q;
    if (rd_gnt) begin
      cen_d  = 1'b0;
      addr_d = rd_addr;
    end else if (wr_ready) begin
      cen_d  = 1'b0;
      wen_d  = 1'b0;
      addr_d = wr_addr;
      din_d  = wr_data;
      sel_d  = wr_sel;
    end else begin
      cen_d  = 1'b1;
    end

    pipe_d = {pipe_q[SRAM_LAT-1:0], rd_gnt};
  end

  // Core state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_NORMAL;
      wait_q  <= 4'd0;
      pipe_q  <= '0;
      cen_q   <= 1'b1;
      wen_q   <= 1'b1;
      addr_q  <= '0;
      din_q   <= '0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      pipe_q  <= pipe_d;
      cen_q   <= cen_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      sel_q   <= sel_d;
    end
  end

  assign load_ack  = (state_q == ST_LOAD);
  assign rd_valid  = pipe_q[SRAM_LAT];
  assign rd_data   = sram_dout;
  assign sram_cen  = cen_q;
  assign sram_wen  = wen_q;
  assign sram_addr = addr_q;
  assign sram_din  = din_q;
  assign sram_sel  = sel_q;

`ifdef ARB_STATS_EN
  logic [15:0] stat_rd_q, stat_rd_d;
  logic [15:0] stat_wr_q, stat_wr_d;
  logic [15:0] stat_stall_q, stat_stall_d;

  // Saturating grant and stall counters
  always_comb begin
    stat_rd_d    = stat_rd_q;
    stat_wr_d    = stat_wr_q;
    stat_stall_d = stat_stall_q;
    if (rd_gnt && stat_rd_q != 16'hFFFF) begin
      stat_rd_d = stat_rd_q + 16'd1;
    end else begin
      stat_rd_d = stat_rd_q;
    end
    if (wr_ready && stat_wr_q != 16'hFFFF) begin
      stat_wr_d = stat_wr_q + 16'd1;
    end else begin
      stat_wr_d = stat_wr_q;
    end
    if ((rd_req || wr_valid) && !rd_gnt && !wr_ready && stat_stall_q != 16'hFFFF) begin
      stat_stall_d = stat_stall_q + 16'd1;
    end else begin
      stat_stall_d = stat_stall_q;
    end
  end

  // Statistics registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_rd_q    <= 16'd0;
      stat_wr_q    <= 16'd0;
      stat_stall_q <= 16'd0;
    end else begin
      stat_rd_q    <= stat_rd_d;
      stat_wr_q    <= stat_wr_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_rd    = stat_rd_q;
  assign stat_wr    = stat_wr_q;
  assign stat_stall = stat_stall_q;
`else
  assign stat_rd    = 16'd0;
  assign stat_wr    = 16'd0;
  assign stat_stall = 16'd0;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized bench for sram_port_arbiter against a cycle-level behavioural model.
module tb_sram_port_arbiter;

  localparam int LAT  = 1;
  localparam int MAXW = 7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_req = 1'b0;
  logic [10:0] rd_addr = 11'd0;
  logic        rd_gnt, rd_valid;
  logic [15:0] rd_data;
  logic        wr_valid = 1'b0;
  logic [10:0] wr_addr = 11'd0;
  logic        wr_sel = 1'b0;
  logic [7:0]  wr_data = 8'd0;
  logic        wr_ready;
  logic        load_req = 1'b0;
  logic        load_ack;
  logic        sram_cen, sram_wen, sram_sel;
  logic [10:0] sram_addr;
  logic [7:0]  sram_din;
  logic [15:0] sram_dout = 16'd0;
  logic [15:0] stat_rd, stat_wr, stat_stall;

  sram_port_arbiter #(.ADDR_W(11), .WDATA_W(8), .RDATA_W(16), .SRAM_LAT(LAT), .WR_MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_sel(wr_sel), .wr_data(wr_data), .wr_ready(wr_ready),
    .load_req(load_req), .load_ack(load_ack),
    .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_addr(sram_addr), .sram_din(sram_din),
    .sram_sel(sram_sel), .sram_dout(sram_dout),
    .stat_rd(stat_rd), .stat_wr(stat_wr), .stat_stall(stat_stall)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [15:0] rd_word(input logic [10:0] a);
    return {5'd0, a} ^ 16'hC35A;
  endfunction

  // Behavioural model: mode 0 normal, 1 drain, 2 load
  typedef struct { int due; logic [15:0] data; } rd_t;
  rd_t         exp_q[$];
  int          m_mode, m_wait, m_last_due;
  logic        m_cen, m_wen, m_sel;
  logic [10:0] m_addr;
  logic [7:0]  m_din;
  int          m_srd, m_swr, m_sst;
  logic        m_rd_g, m_wr_g;

  // Tiny SRAM stand-in: replies with a word derived from the read address
  logic        hist_rd [8];
  logic [10:0] hist_addr [8];

  task automatic model_clear();
    exp_q.delete();
    m_mode = 0; m_wait = 0; m_last_due = -1000;
    m_cen = 1'b1; m_wen = 1'b1; m_sel = 1'b0; m_addr = 11'd0; m_din = 8'd0;
    m_srd = 0; m_swr = 0; m_sst = 0;
    m_rd_g = 1'b0; m_wr_g = 1'b0;
    for (int i = 0; i < 8; i++) begin
      hist_rd[i] = 1'b0;
      hist_addr[i] = 11'd0;
    end
  endtask

  task automatic check_reset_state();
    check_val("rst_cen", 32'(sram_cen), 32'd1);
    check_val("rst_wen", 32'(sram_wen), 32'd1);
    check_val("rst_addr", 32'(sram_addr), 32'd0);
    check_val("rst_din", 32'(sram_din), 32'd0);
    check_val("rst_sel", 32'(sram_sel), 32'd0);
    check_val("rst_rd_valid", 32'(rd_valid), 32'd0);
    check_val("rst_load_ack", 32'(load_ack), 32'd0);
    check_val("rst_stat_rd", 32'(stat_rd), 32'd0);
    check_val("rst_stat_wr", 32'(stat_wr), 32'd0);
    check_val("rst_stat_stall", 32'(stat_stall), 32'd0);
  endtask

  task automatic run_cycle(input int p_rd, input int p_wr, input int p_tog, input bit no_load);
    logic rg, wg, ev;
    int   li;
    @(negedge clk);
    cyc++;
    hist_rd[cyc & 7]   = ~sram_cen & sram_wen;
    hist_addr[cyc & 7] = sram_addr;
    li = (cyc - LAT) & 7;
    sram_dout = hist_rd[li] ? rd_word(hist_addr[li]) : 16'($urandom);

    if (!(rd_req && !m_rd_g)) begin
      rd_req  = ($urandom_range(0, 99) < p_rd);
      rd_addr = 11'($urandom);
    end
    if (!(wr_valid && !m_wr_g)) begin
      wr_valid = ($urandom_range(0, 99) < p_wr);
      wr_addr  = 11'($urandom);
      wr_data  = 8'($urandom);
      wr_sel   = 1'($urandom);
    end
    if (no_load) load_req = 1'b0;
    else if ($urandom_range(0, 99) < p_tog) load_req = ~load_req;
    #1;

    rg = 1'b0; wg = 1'b0;
    if (m_mode == 0) begin
      if (rd_req && wr_valid) begin
        if (m_wait == MAXW) wg = 1'b1; else rg = 1'b1;
      end else begin
        rg = rd_req; wg = wr_valid;
      end
    end else if (m_mode == 2) begin
      wg = wr_valid;
    end

    check_val("rd_gnt", 32'(rd_gnt), 32'(rg));
    check_val("wr_ready", 32'(wr_ready), 32'(wg));
    check_val("load_ack", 32'(load_ack), 32'(m_mode == 2));
    check_val("sram_cen", 32'(sram_cen), 32'(m_cen));
    check_val("sram_wen", 32'(sram_wen), 32'(m_wen));
    check_val("sram_addr", 32'(sram_addr), 32'(m_addr));
    check_val("sram_din", 32'(sram_din), 32'(m_din));
    check_val("sram_sel", 32'(sram_sel), 32'(m_sel));
    ev = (exp_q.size() > 0) && (exp_q[0].due == cyc);
    check_val("rd_valid", 32'(rd_valid), 32'(ev));
    if (ev) begin
      check_val("rd_data", 32'(rd_data), 32'(exp_q[0].data));
      void'(exp_q.pop_front());
    end
`ifdef ARB_STATS_EN
    check_val("stat_rd", 32'(stat_rd), 32'(m_srd));
    check_val("stat_wr", 32'(stat_wr), 32'(m_swr));
    check_val("stat_stall", 32'(stat_stall), 32'(m_sst));
`else
    check_val("stat_rd", 32'(stat_rd), 32'd0);
    check_val("stat_wr", 32'(stat_wr), 32'd0);
    check_val("stat_stall", 32'(stat_stall), 32'd0);
`endif

    if (rg) begin
      m_cen = 1'b0; m_wen = 1'b1; m_addr = rd_addr;
      m_last_due = cyc + 1 + LAT;
      exp_q.push_back('{due: cyc + 1 + LAT, data: rd_word(rd_addr)});
    end else if (wg) begin
      m_cen = 1'b0; m_wen = 1'b0; m_addr = wr_addr; m_din = wr_data; m_sel = wr_sel;
    end else begin
      m_cen = 1'b1; m_wen = 1'b1;
    end
    if (wg || !wr_valid) m_wait = 0;
    else if (m_wait < MAXW) m_wait++;
    if (rg && m_srd < 65535) m_srd++;
    if (wg && m_swr < 65535) m_swr++;
    if ((rd_req || wr_valid) && !rg && !wg && m_sst < 65535) m_sst++;
    case (m_mode)
      0: m_mode = load_req ? 1 : 0;
      1: m_mode = !load_req ? 0 : ((m_last_due < cyc) ? 2 : 1);
      default: m_mode = load_req ? 2 : 0;
    endcase
    m_rd_g = rg; m_wr_g = wg;
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    #1;
    check_reset_state();
    model_clear();
    rd_req = 1'b0; wr_valid = 1'b0; load_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_clear();
    repeat (3) @(negedge clk);
    check_reset_state();
    rst_n = 1'b1;
    for (int ph = 0; ph < 5; ph++) begin
      for (int k = 0; k < 500; k++) begin
        case (ph)
          0: run_cycle(50, 50, 2, 1'b0);
          1: run_cycle(100, 100, 0, 1'b1);
          2: run_cycle(80, 30, 5, 1'b0);
          3: run_cycle(90, 90, 3, 1'b0);
          default: begin
            run_cycle(60, 40, 4, 1'b0);
            if ($urandom_range(0, 99) < 3) do_reset();
          end
        endcase
      end
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
